wb_dcache_ctrl: RTL and testbench
=================================

Name: wb_dcache_ctrl

Overview:
- FSM that sequences the write-back data cache datapath and its victim cache for one LSU/MMU requester and one memory port.
- Covers: lookup, write hit, victim swap, dirty writeback, line allocate, whole-cache flush.
- Sits between the LSU/MMU handshake, the dcache datapath control inputs and the memory request/ack interface.
- Invariant: the victim cache only ever holds clean lines.

Parameters:
- DCACHE_IDX_BITS, 7, index width; the cache has 2^DCACHE_IDX_BITS lines.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- lsummu2dcache_req_i  in  1  LSU request valid, held until ack
- lsummu2dcache_wr_i  in  1  1 = store, 0 = load; stable while req is high
- dcache_flush_i  in  1  flush request, held until flush ack
- cache_hit_i  in  1  datapath tag match, valid one cycle after an index is presented
- cache_evict_req_i  in  1  read line dirty
- dcache_valid_i  in  1  read line valid
- victim_hit_i  in  1  victim cache holds the requested line
- mem2dcache_ack_i  in  1  memory transfer done (1-cycle pulse)
- dcache2lsummu_ack_o  out  1  request complete (1-cycle pulse)
- dcache_flush_ack_o  out  1  flush complete (1-cycle pulse)
- dcache2mem_req_o  out  1  memory request
- dcache2mem_wr_o  out  1  1 = writeback, 0 = line fill
- cache_wr_o  out  1  word write into cache, sets dirty
- cache_line_wr_o  out  1  fill line from memory
- cache_line_clean_o  out  1  clear dirty bit
- cache_wrb_req_o  out  1  select writeback address
- evict_index_o  out  DCACHE_IDX_BITS  flush walk index
- write_to_victim_o  out  1  copy the displaced line into the victim cache
- write_from_victim_o  out  1  load the victim line into the cache
- lsu_victim_mux_sel_o  out  1  return load data from the victim path

Behaviour:
- Reset: rst_n, synchronous, active-low; clock clk. Reset puts the FSM in IDLE, clears evict_index_o and drives every output 0.
- Reset mid-operation abandons any memory transaction; memory must tolerate a dropped req.
- All outputs are combinational decodes of state plus inputs, except the registered evict_index_o.
- States: IDLE, LOOKUP, WRBACK, VICTIM_SWAP, VICTIM_PUT, ALLOCATE, FL_READ, FL_CHK, FL_WB, FL_DONE.
- IDLE:
  - dcache_flush_i has priority over a simultaneous request: go to FL_READ with index 0.
  - Otherwise req goes to LOOKUP; tag/data RAM read has 1-cycle latency.
- LOOKUP:
  - cache_hit_i and load: ack, go to IDLE. Load latency 2 cycles from req.
  - cache_hit_i and store: cache_wr_o = 1 for one cycle, ack the same cycle, go to IDLE.
  - Miss with dcache_valid_i & cache_evict_req_i: go to WRBACK.
  - Miss with victim_hit_i: go to VICTIM_SWAP.
  - Miss with dcache_valid_i (clean line): go to VICTIM_PUT.
  - Any other miss: go to ALLOCATE.
- WRBACK:
  - Hold dcache2mem_req_o = dcache2mem_wr_o = cache_wrb_req_o = 1 until mem2dcache_ack_i.
  - On ack, cache_line_clean_o = 1 for one cycle, then apply the LOOKUP miss-routing using the values sampled in LOOKUP (victim hit goes to VICTIM_SWAP, else VICTIM_PUT).
- VICTIM_SWAP:
  - One cycle: write_from_victim_o = 1; write_to_victim_o = 1 only if the displaced line was valid.
  - Load: lsu_victim_mux_sel_o = 1 and ack this cycle, go to IDLE.
  - Store: return to LOOKUP, which replays and hits.
- VICTIM_PUT: one cycle, write_to_victim_o = 1, go to ALLOCATE.
- ALLOCATE:
  - Hold dcache2mem_req_o = 1, dcache2mem_wr_o = 0 until ack.
  - On the ack cycle cache_line_wr_o = 1, then go to LOOKUP (replay guaranteed hit).
- Flush walk:
  - FL_READ: present evict_index_o, one cycle.
  - FL_CHK: valid & dirty goes to FL_WB; otherwise increment the index.
  - FL_WB: memory write as in WRBACK; on ack, cache_line_clean_o pulse, then increment the index.
  - After the increment: if the index wrapped from 2^DCACHE_IDX_BITS-1 to 0, go to FL_DONE; else go to FL_READ.
  - FL_DONE: dcache_flush_ack_o = 1 for one cycle, go to IDLE.
  - The victim cache needs no flush (clean-only invariant).
- Mutual exclusion: at most one of cache_wr_o, cache_line_wr_o, write_from_victim_o, cache_line_clean_o is high in any cycle.
- dcache2lsummu_ack_o is never asserted during a flush.
- Ignored inputs: lsummu2dcache_req_i while flushing, and mem2dcache_ack_i outside WRBACK, ALLOCATE and FL_WB.

Optional Feature:
- Macro DCACHE_VICTIM_EN.
- Defined: victim states and outputs behave as above.
- Undefined:
  - VICTIM_SWAP and VICTIM_PUT are removed; victim_hit_i is ignored.
  - write_to_victim_o, write_from_victim_o and lsu_victim_mux_sel_o are tied 0.
  - Every miss goes WRBACK (if dirty) then ALLOCATE.

Test Plan:
- Load hit: req with cache_hit_i = 1 in LOOKUP -> ack at cycle 2, no memory req, no cache writes.
- Store miss, clean valid line, victim_hit_i = 0 -> VICTIM_PUT pulse, ALLOCATE with mem ack after 5 cycles and cache_line_wr_o on that cycle, replay hit, cache_wr_o + ack together.
- Load miss, dirty line, victim hit -> WRBACK (wr = 1, wrb = 1) until ack, clean pulse, then one VICTIM_SWAP cycle with mux_sel = 1, write_from = 1, write_to = 1 and ack.
- Flush with DCACHE_IDX_BITS = 3, lines 2 and 7 dirty -> exactly 2 memory writes at indices 2 and 7, 2 clean pulses, flush ack once after index 7, evict_index_o returns to 0.
- Simultaneous req and flush in IDLE -> flush runs to completion first, then request acked. Reset asserted mid-ALLOCATE -> all outputs 0 next cycle, state IDLE.
- Build without DCACHE_VICTIM_EN, victim_hit_i = 1 on miss -> ALLOCATE taken, victim outputs stay 0.

Source files
------------

// File: rtl/wb_dcache_ctrl_if.sv
// Handshake bundle between the write-back dcache controller, the LSU/MMU,
// the dcache/victim datapath and the memory port.
interface wb_dcache_ctrl_if #(
    parameter int DCACHE_IDX_BITS = 7
);
    logic                       lsummu2dcache_req_i;
    logic                       lsummu2dcache_wr_i;
    logic                       dcache_flush_i;
    logic                       cache_hit_i;
    logic                       cache_evict_req_i;
    logic                       dcache_valid_i;
    logic                       victim_hit_i;
    logic                       mem2dcache_ack_i;
    logic                       dcache2lsummu_ack_o;
    logic                       dcache_flush_ack_o;
    logic                       dcache2mem_req_o;
    logic                       dcache2mem_wr_o;
    logic                       cache_wr_o;
    logic                       cache_line_wr_o;
    logic                       cache_line_clean_o;
    logic                       cache_wrb_req_o;
    logic [DCACHE_IDX_BITS-1:0] evict_index_o;
    logic                       write_to_victim_o;
    logic                       write_from_victim_o;
    logic                       lsu_victim_mux_sel_o;

    // Controller side.
    modport master (
        input  lsummu2dcache_req_i, lsummu2dcache_wr_i, dcache_flush_i,
               cache_hit_i, cache_evict_req_i, dcache_valid_i,
               victim_hit_i, mem2dcache_ack_i,
        output dcache2lsummu_ack_o, dcache_flush_ack_o, dcache2mem_req_o,
               dcache2mem_wr_o, cache_wr_o, cache_line_wr_o,
               cache_line_clean_o, cache_wrb_req_o, evict_index_o,
               write_to_victim_o, write_from_victim_o, lsu_victim_mux_sel_o
    );

    // Requester / datapath / memory side.
    modport slave (
        output lsummu2dcache_req_i, lsummu2dcache_wr_i, dcache_flush_i,
               cache_hit_i, cache_evict_req_i, dcache_valid_i,
               victim_hit_i, mem2dcache_ack_i,
        input  dcache2lsummu_ack_o, dcache_flush_ack_o, dcache2mem_req_o,
               dcache2mem_wr_o, cache_wr_o, cache_line_wr_o,
               cache_line_clean_o, cache_wrb_req_o, evict_index_o,
               write_to_victim_o, write_from_victim_o, lsu_victim_mux_sel_o
    );
endinterface

// File: rtl/wb_dcache_ctrl.sv
// Write-back dcache controller: lookup, store hit, dirty writeback, allocate, flush walk.
// Victim cache swap/put paths exist only when DCACHE_VICTIM_EN is defined.
module wb_dcache_ctrl #(
    parameter int DCACHE_IDX_BITS = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_dcache_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        LOOKUP,
        WRBACK,
`ifdef DCACHE_VICTIM_EN
        VICTIM_SWAP,
        VICTIM_PUT,
`endif
        ALLOCATE,
        FL_READ,
        FL_CHK,
        FL_WB,
        FL_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [DCACHE_IDX_BITS-1:0] idx_q;
    logic                       idx_clr, idx_inc;

    logic ack, flush_ack, mem_req, mem_wr, cache_wr, line_wr, line_clean, wrb_req;
`ifdef DCACHE_VICTIM_EN
    logic vhit_q, valid_q;
    logic to_victim, from_victim, victim_sel;
`else
    logic unused_victim_hit;
    assign unused_victim_hit = bus.victim_hit_i;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
`ifdef DCACHE_VICTIM_EN
            vhit_q  <= 1'b0;
            valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (idx_clr)      idx_q <= '0;
            else if (idx_inc) idx_q <= idx_q + 1'b1;
`ifdef DCACHE_VICTIM_EN
            // Miss routing after a writeback reuses what the lookup saw.
            if (state_q == LOOKUP) begin
                vhit_q  <= bus.victim_hit_i;
                valid_q <= bus.dcache_valid_i;
            end
`endif
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path infers a latch.
        state_d    = state_q;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        ack        = 1'b0;
        flush_ack  = 1'b0;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        cache_wr   = 1'b0;
        line_wr    = 1'b0;
        line_clean = 1'b0;
        wrb_req    = 1'b0;
`ifdef DCACHE_VICTIM_EN
        to_victim   = 1'b0;
        from_victim = 1'b0;
        victim_sel  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.dcache_flush_i) begin
                    idx_clr = 1'b1;
                    state_d = FL_READ;
                end else if (bus.lsummu2dcache_req_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.cache_hit_i) begin
                    ack      = 1'b1;
                    cache_wr = bus.lsummu2dcache_wr_i;
                    state_d  = IDLE;
                end else if (bus.dcache_valid_i && bus.cache_evict_req_i) begin
                    state_d = WRBACK;
`ifdef DCACHE_VICTIM_EN
                end else if (bus.victim_hit_i) begin
                    state_d = VICTIM_SWAP;
                end else if (bus.dcache_valid_i) begin
                    state_d = VICTIM_PUT;
`endif
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRBACK: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                wrb_req = 1'b1;
                if (bus.mem2dcache_ack_i) begin
                    line_clean = 1'b1;
`ifdef DCACHE_VICTIM_EN
                    // The line is clean now, so it may move to the victim cache.
                    state_d = vhit_q ? VICTIM_SWAP : VICTIM_PUT;
`else
                    state_d = ALLOCATE;
`endif
                end
            end
`ifdef DCACHE_VICTIM_EN
            VICTIM_SWAP: begin
                from_victim = 1'b1;
                to_victim   = valid_q;
                if (bus.lsummu2dcache_wr_i) begin
                    state_d = LOOKUP;
                end else begin
                    victim_sel = 1'b1;
                    ack        = 1'b1;
                    state_d    = IDLE;
                end
            end
            VICTIM_PUT: begin
                to_victim = 1'b1;
                state_d   = ALLOCATE;
            end
`endif
            ALLOCATE: begin
                mem_req = 1'b1;
                if (bus.mem2dcache_ack_i) begin
                    line_wr = 1'b1;
                    state_d = LOOKUP;
                end
            end
            FL_READ: state_d = FL_CHK;
            FL_CHK: begin
                if (bus.dcache_valid_i && bus.cache_evict_req_i) begin
                    state_d = FL_WB;
                end else begin
                    idx_inc = 1'b1;
                    state_d = (&idx_q) ? FL_DONE : FL_READ;
                end
            end
            FL_WB: begin
                mem_req = 1'b1;
                mem_wr  = 1'b1;
                wrb_req = 1'b1;
                if (bus.mem2dcache_ack_i) begin
                    line_clean = 1'b1;
                    idx_inc    = 1'b1;
                    state_d    = (&idx_q) ? FL_DONE : FL_READ;
                end
            end
            FL_DONE: begin
                flush_ack = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dcache2lsummu_ack_o = ack;
    assign bus.dcache_flush_ack_o  = flush_ack;
    assign bus.dcache2mem_req_o    = mem_req;
    assign bus.dcache2mem_wr_o     = mem_wr;
    assign bus.cache_wr_o          = cache_wr;
    assign bus.cache_line_wr_o     = line_wr;
    assign bus.cache_line_clean_o  = line_clean;
    assign bus.cache_wrb_req_o     = wrb_req;
    assign bus.evict_index_o       = idx_q;
`ifdef DCACHE_VICTIM_EN
    assign bus.write_to_victim_o    = to_victim;
    assign bus.write_from_victim_o  = from_victim;
    assign bus.lsu_victim_mux_sel_o = victim_sel;
`else
    assign bus.write_to_victim_o    = 1'b0;
    assign bus.write_from_victim_o  = 1'b0;
    assign bus.lsu_victim_mux_sel_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_dcache_ctrl.sv
// Scoreboard bench for wb_dcache_ctrl: directed scenarios push expected events,
// a negedge monitor pops and compares each event the controller presents.
module tb_wb_dcache_ctrl;

    localparam int IDX     = 3;
    localparam int MEM_LAT = 5;
    localparam int BUDGET  = 200;

    // Flag bits of an observed event, most significant first.
    localparam logic [10:0] F_ACK   = 11'b100_0000_0000;
    localparam logic [10:0] F_FACK  = 11'b010_0000_0000;
    localparam logic [10:0] F_MUX   = 11'b001_0000_0000;
    localparam logic [10:0] F_CWR   = 11'b000_1000_0000;
    localparam logic [10:0] F_LWR   = 11'b000_0100_0000;
    localparam logic [10:0] F_CLN   = 11'b000_0010_0000;
    localparam logic [10:0] F_TOV   = 11'b000_0001_0000;
    localparam logic [10:0] F_FROMV = 11'b000_0000_1000;
    localparam logic [10:0] F_MREQ  = 11'b000_0000_0100;
    localparam logic [10:0] F_MWR   = 11'b000_0000_0010;
    localparam logic [10:0] F_WRB   = 11'b000_0000_0001;

    typedef struct packed {
        logic [10:0]    flags;
        logic [IDX-1:0] idx;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_dcache_ctrl_if #(.DCACHE_IDX_BITS(IDX)) bus();
    wb_dcache_ctrl #(.DCACHE_IDX_BITS(IDX)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic           req_d, wr_d, flush_d, hit_d, valid_d, evict_d, vhit_d, mem_ack_d;
    logic           flush_mode;
    logic [7:0]     dirty_arr;
    int             mem_cnt;
    logic           seen_ack, seen_fack, seen_mreq;
    int             last_lat;
    int             n_checks = 0;
    int             n_fail   = 0;
    obs_t           sb[$];

    assign bus.lsummu2dcache_req_i = req_d;
    assign bus.lsummu2dcache_wr_i  = wr_d;
    assign bus.dcache_flush_i      = flush_d;
    assign bus.cache_hit_i         = hit_d;
    assign bus.dcache_valid_i      = flush_mode ? 1'b1 : valid_d;
    assign bus.cache_evict_req_i   = flush_mode ? dirty_arr[bus.evict_index_o] : evict_d;
    assign bus.victim_hit_i        = vhit_d;
    assign bus.mem2dcache_ack_i    = mem_ack_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t ev(input logic [10:0] flags, input logic [IDX-1:0] idx);
        obs_t o;
        o.flags = flags;
        o.idx   = idx;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.flags = {bus.dcache2lsummu_ack_o, bus.dcache_flush_ack_o, bus.lsu_victim_mux_sel_o,
                   bus.cache_wr_o, bus.cache_line_wr_o, bus.cache_line_clean_o,
                   bus.write_to_victim_o, bus.write_from_victim_o,
                   bus.dcache2mem_req_o, bus.dcache2mem_wr_o, bus.cache_wrb_req_o};
        o.idx   = bus.evict_index_o;
        return o;
    endfunction

    // Monitor: an event is any pulse output or the start of a memory transfer.
    logic prev_req = 1'b0;
    logic prev_wr  = 1'b0;
    always @(negedge clk) begin
        obs_t o;
        logic  trig;
        o    = sample();
        trig = (|o.flags[10:3]) || (o.flags[2] && (!prev_req || prev_wr != o.flags[1]));
        if (rst_n && trig) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'(o), 32'h0);
            end else begin
                check("event", 32'(o), 32'(sb.pop_front()));
            end
        end
        prev_req = o.flags[2];
        prev_wr  = o.flags[1];
    end

    // One clock of stimulus plus the datapath and memory models.
    task automatic tick();
        logic lw, wf, cl, mr;
        @(negedge clk);
        lw        = bus.cache_line_wr_o;
        wf        = bus.write_from_victim_o;
        cl        = bus.cache_line_clean_o;
        mr        = bus.dcache2mem_req_o;
        seen_ack  = bus.dcache2lsummu_ack_o;
        seen_fack = bus.dcache_flush_ack_o;
        seen_mreq = mr;
        @(posedge clk);
        #1;
        if (lw || wf) hit_d = 1'b1;
        if (cl)       evict_d = 1'b0;
        if (mem_ack_d) begin
            mem_ack_d = 1'b0;
            mem_cnt   = 0;
        end else if (mr) begin
            mem_cnt++;
            if (mem_cnt >= MEM_LAT) mem_ack_d = 1'b1;
        end
    endtask

    task automatic wait_ack(input string name, input bit is_flush);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(is_flush ? seen_fack : seen_ack) && n < BUDGET);
        check({name, "_done"}, 32'(is_flush ? seen_fack : seen_ack), 32'h1);
        last_lat = n;
    endtask

    task automatic start_req(input logic wr, input logic hit, input logic valid,
                             input logic dirty, input logic vhit);
        wr_d    = wr;
        hit_d   = hit;
        valid_d = valid;
        evict_d = dirty;
        vhit_d  = vhit;
        req_d   = 1'b1;
    endtask

    task automatic end_req();
        req_d   = 1'b0;
        hit_d   = 1'b0;
        valid_d = 1'b0;
        evict_d = 1'b0;
        vhit_d  = 1'b0;
        wr_d    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        end_req();
        flush_d    = 1'b0;
        flush_mode = 1'b0;
        mem_ack_d  = 1'b0;
        mem_cnt    = 0;
        dirty_arr  = 8'b1000_0100;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(sample()), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load hit: ack on the second cycle, nothing else.
        sb.push_back(ev(F_ACK, 0));
        start_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_ack("load_hit", 1'b0);
        check("load_hit_latency", 32'(last_lat), 32'd2);
        end_req();
        tick();

        // Store miss on a clean valid line, no victim hit.
`ifdef DCACHE_VICTIM_EN
        sb.push_back(ev(F_TOV, 0));
`endif
        sb.push_back(ev(F_MREQ, 0));
        sb.push_back(ev(F_MREQ | F_LWR, 0));
        sb.push_back(ev(F_ACK | F_CWR, 0));
        start_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_ack("store_miss_clean", 1'b0);
        end_req();
        tick();

        // Load miss on a dirty line with a victim hit.
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB, 0));
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB | F_CLN, 0));
`ifdef DCACHE_VICTIM_EN
        sb.push_back(ev(F_ACK | F_MUX | F_FROMV | F_TOV, 0));
`else
        sb.push_back(ev(F_MREQ, 0));
        sb.push_back(ev(F_MREQ | F_LWR, 0));
        sb.push_back(ev(F_ACK, 0));
`endif
        start_req(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_ack("load_miss_dirty_vhit", 1'b0);
        end_req();
        tick();

        // Store miss on an invalid line with a victim hit.
`ifdef DCACHE_VICTIM_EN
        sb.push_back(ev(F_FROMV, 0));
`else
        sb.push_back(ev(F_MREQ, 0));
        sb.push_back(ev(F_MREQ | F_LWR, 0));
`endif
        sb.push_back(ev(F_ACK | F_CWR, 0));
        start_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_ack("store_miss_invalid_vhit", 1'b0);
        end_req();
        tick();

        // Load miss on an invalid line, no victim.
        sb.push_back(ev(F_MREQ, 0));
        sb.push_back(ev(F_MREQ | F_LWR, 0));
        sb.push_back(ev(F_ACK, 0));
        start_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ack("load_miss_invalid", 1'b0);
        end_req();
        tick();

        // Flush and request together: lines 2 and 7 dirty, flush wins.
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB, 3'd2));
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB | F_CLN, 3'd2));
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB, 3'd7));
        sb.push_back(ev(F_MREQ | F_MWR | F_WRB | F_CLN, 3'd7));
        sb.push_back(ev(F_FACK, 0));
        sb.push_back(ev(F_ACK, 0));
        flush_mode = 1'b1;
        flush_d    = 1'b1;
        start_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_ack("flush", 1'b1);
        flush_d    = 1'b0;
        flush_mode = 1'b0;
        hit_d      = 1'b1;
        wait_ack("req_after_flush", 1'b0);
        check("flush_index_wrapped", 32'(bus.evict_index_o), 32'h0);
        end_req();
        tick();

        // Reset in the middle of an allocate.
        sb.push_back(ev(F_MREQ, 0));
        start_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (!seen_mreq && n < BUDGET);
            check("alloc_started", 32'(seen_mreq), 32'h1);
        end
        rst_n     = 1'b0;
        mem_ack_d = 1'b0;
        mem_cnt   = 0;
        end_req();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_mid_alloc", 32'(sample()), 32'h0);
        @(posedge clk);
        #1;

        // Recovery: a plain load hit after the abandoned transfer.
        sb.push_back(ev(F_ACK, 0));
        start_req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_ack("load_hit_after_reset", 1'b0);
        end_req();
        repeat (3) tick();

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
